// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between N_REQ requesters.
// Each grant issues a one-cycle write strobe followed by a SETTLE-cycle low gap.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*WIDTH-1:0]     data_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic                       fifo_wr_o,
  output logic [WIDTH-1:0]           fifo_din_o,
  input  logic                       fifo_full_i,
  output logic [$clog2(N_REQ)-1:0]   grant_o,
  output logic                       busy_o
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StWr, StGap} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [GW-1:0]    winner;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = data_i[k*WIDTH +: WIDTH];
  end

  // Search starts just after the previous winner and wraps, so the last
  // requester served has the lowest priority next time.
  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [GW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx  = (32'(last_q) + i) % N_REQ;
      cand = GW'(idx);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    fifo_wr_o = 1'b0;
    ack_o     = '0;
    unique case (state_q)
      StIdle: begin
        if (|req_i && !fifo_full_i) begin
          grant_d = winner;
          din_d   = data_arr[winner];
          state_d = StWr;
        end
      end
      StWr: begin
        fifo_wr_o       = 1'b1;
        ack_o[grant_q]  = 1'b1;
        last_d          = grant_q;
        cnt_d           = CW'(SETTLE - 1);
        state_d         = StGap;
      end
      StGap: begin
        // Strobe held low so the FIFO edge detector and full flag settle.
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      din_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o    = grant_q;
  assign fifo_din_o = din_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small 4-deep FIFO model on the write port.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [15:0] din;
  logic        full;
  logic [1:0]  grant;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(16), .SETTLE(2)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_i       (req),
    .data_i      (data),
    .ack_o       (ack),
    .fifo_wr_o   (fifo_wr),
    .fifo_din_o  (din),
    .fifo_full_i (full),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  // FIFO model, depth 4, sharing rstn with the arbiter
  logic [15:0] mem [4];
  logic [1:0]  wp, rp;
  int          cnt;
  logic        rd;

  assign full = (cnt == 4);

  always @(posedge clk) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= 0;
    end else begin
      if (fifo_wr && cnt < 4) begin
        mem[wp] <= din;
        wp      <= wp + 2'd1;
      end
      if (rd && cnt > 0) rp <= rp + 2'd1;
      cnt <= cnt + ((fifo_wr && cnt < 4) ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
    end
  end

  task automatic fifo_pop(output logic [15:0] d);
    d  = mem[rp];
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    data = '0;
    rd   = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_wr(input int max, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      if (fifo_wr) seen = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (fifo_wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %0b exp 0", fifo_wr); end
    tests++; if (din !== 16'h0) begin fails++; $display("FAIL reset_din: got %0h exp 0", din); end
    tests++; if (ack !== 4'b0) begin fails++; $display("FAIL reset_ack: got %0b exp 0", ack); end
    tests++; if (grant !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d exp 0", grant); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_single();
    bit seen;
    int n;
    logic [15:0] d;
    data[47:32] = 16'hA5A5;
    req = 4'b0100;
    wait_wr(6, seen, n);
    tests++; if (!seen || n != 1) begin fails++; $display("FAIL single_latency: got seen=%0b n=%0d exp seen=1 n=1", seen, n); end
    tests++; if (ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %0b exp 0100", ack); end
    tests++; if (grant !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d exp 2", grant); end
    tests++; if (din !== 16'hA5A5) begin fails++; $display("FAIL single_din: got %0h exp a5a5", din); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_wr: got %0b exp 1", busy); end
    req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (fifo_wr !== 1'b0 || ack !== 4'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL single_gap%0d: got wr=%0b ack=%0b busy=%0b exp 0 0 1", i, fifo_wr, ack, busy);
      end
    end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got busy=%0b exp 0", busy); end
    tests++; if (din !== 16'hA5A5) begin fails++; $display("FAIL single_din_hold: got %0h exp a5a5", din); end
    fifo_pop(d);
    tests++; if (d !== 16'hA5A5) begin fails++; $display("FAIL single_fifo: got %0h exp a5a5", d); end
  endtask

  task automatic test_all_four();
    bit seen;
    int n;
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h0000; exp_d[1] = 16'h1111; exp_d[2] = 16'h2222; exp_d[3] = 16'h3333;
    do_reset();
    data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_wr(8, seen, n);
      tests++;
      if (!seen || ack !== (4'b0001 << k) || grant !== 2'(k) || din !== exp_d[k]) begin
        fails++;
        $display("FAIL all4_grant%0d: got seen=%0b ack=%0b grant=%0d din=%0h exp ack=%0b grant=%0d din=%0h",
                 k, seen, ack, grant, din, 4'b0001 << k, k, exp_d[k]);
      end
      if (k > 0) begin
        tests++; if (n != 4) begin fails++; $display("FAIL all4_spacing%0d: got %0d exp 4", k, n); end
      end
      req[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL all4_full: got %0b exp 1", full); end
  endtask

  task automatic test_full_block();
    bit seen;
    int n;
    int bad = 0;
    logic [15:0] d;
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    data[15:0] = 16'h4444;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_wr !== 1'b0 || ack !== 4'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL full_block: got %0d write cycles exp 0", bad); end
    fifo_pop(d);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL full_pop0: got %0h exp 0000", d); end
    wait_wr(3, seen, n);
    tests++;
    if (!seen || ack !== 4'b0001 || grant !== 2'd0) begin
      fails++;
      $display("FAIL full_release: got seen=%0b ack=%0b grant=%0d exp 1 0001 0", seen, ack, grant);
    end
    req = 4'b0000;
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      fifo_pop(d);
      tests++; if (d !== exp_d[k]) begin fails++; $display("FAIL full_drain%0d: got %0h exp %0h", k, d, exp_d[k]); end
    end
  endtask

  task automatic test_round_robin();
    bit seen;
    int n;
    logic [15:0] d;
    data = {16'h0, 16'h2002, 16'h1001, 16'h1000};
    req = 4'b0010;
    wait_wr(6, seen, n);
    tests++; if (!seen || grant !== 2'd1) begin fails++; $display("FAIL rr_first: got seen=%0b grant=%0d exp 1 1", seen, grant); end
    req = 4'b0000;
    wait_idle();
    req = 4'b0011;
    wait_wr(6, seen, n);
    tests++;
    if (!seen || grant !== 2'd0 || ack !== 4'b0001) begin
      fails++;
      $display("FAIL rr_after1: got seen=%0b grant=%0d ack=%0b exp 1 0 0001", seen, grant, ack);
    end
    req = 4'b0000;
    wait_idle();
    req = 4'b0100;
    wait_wr(6, seen, n);
    tests++; if (!seen || grant !== 2'd2) begin fails++; $display("FAIL rr_third: got seen=%0b grant=%0d exp 1 2", seen, grant); end
    req = 4'b0000;
    wait_idle();
    data[15:0] = 16'h1003;
    req = 4'b0101;
    wait_wr(6, seen, n);
    tests++;
    if (!seen || grant !== 2'd0 || din !== 16'h1003) begin
      fails++;
      $display("FAIL rr_wrap: got seen=%0b grant=%0d din=%0h exp 1 0 1003", seen, grant, din);
    end
    req = 4'b0000;
    wait_idle();
    for (int k = 0; k < 4; k++) fifo_pop(d);
    tests++; if (d !== 16'h1003) begin fails++; $display("FAIL rr_fifo_last: got %0h exp 1003", d); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n;
    int bad = 0;
    logic [15:0] d;
    data[31:16] = 16'h7777;
    req = 4'b0010;
    wait_wr(6, seen, n);
    rstn = 1'b0;
    req  = 4'b0000;
    @(negedge clk);
    tests++;
    if (fifo_wr !== 1'b0 || busy !== 1'b0 || grant !== 2'd0 || ack !== 4'b0) begin
      fails++;
      $display("FAIL midrst_state: got wr=%0b busy=%0b grant=%0d ack=%0b exp 0 0 0 0", fifo_wr, busy, grant, ack);
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fifo_wr !== 1'b0 || ack !== 4'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midrst_noack: got %0d ack cycles exp 0", bad); end
    data[63:48] = 16'h8888;
    req = 4'b1000;
    wait_wr(6, seen, n);
    tests++;
    if (!seen || n != 1 || ack !== 4'b1000 || grant !== 2'd3 || din !== 16'h8888) begin
      fails++;
      $display("FAIL midrst_after: got seen=%0b n=%0d ack=%0b grant=%0d din=%0h exp 1 1 1000 3 8888",
               seen, n, ack, grant, din);
    end
    req = 4'b0000;
    wait_idle();
    fifo_pop(d);
    tests++; if (d !== 16'h8888) begin fails++; $display("FAIL midrst_fifo: got %0h exp 8888", d); end
  endtask

  task automatic test_withdraw();
    bit seen;
    int n;
    int bad = 0;
    logic [15:0] d;
    data[15:0] = 16'h5555;
    req = 4'b0001;
    wait_wr(6, seen, n);
    tests++; if (!seen || grant !== 2'd0) begin fails++; $display("FAIL wd_first: got seen=%0b grant=%0d exp 1 0", seen, grant); end
    req = 4'b0000;
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (fifo_wr !== 1'b0 || ack !== 4'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wd_noack: got %0d write cycles exp 0", bad); end
    tests++; if (grant !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL wd_grant: got grant=%0d busy=%0b exp 0 0", grant, busy); end
    fifo_pop(d);
    tests++; if (d !== 16'h5555) begin fails++; $display("FAIL wd_fifo: got %0h exp 5555", d); end
  endtask

  initial begin
    rstn = 1'b0;
    req  = '0;
    data = '0;
    rd   = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_full_block();
    test_round_robin();
    test_reset_mid();
    test_withdraw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo` write port between `N_REQ` requesters. It selects one pending requester, presents that requester's word on the FIFO data input, and drives a single-cycle write strobe. It then holds the strobe low for a settle gap, so that the FIFO's rising-edge write detector and its `full_o` flag are valid before the next decision. It sits directly in front of the FIFO; the FIFO read side is not touched.

## Interface

- `N_REQ`, 4: number of requesters; legal values are 2 or more.
- `WIDTH`, 16: data width; must equal the FIFO `WIDTH`.
- `SETTLE`, 2: number of cycles `fifo_wr_o` is held low after each write strobe; legal values are 1 or more.
- `clk_i`  in  1  single clock; all logic is on its rising edge.
- `rstn_i`  in  1  reset, synchronous and active-low.
- `req_i`  in  N_REQ  per-requester write request; level-sensitive.
- `data_i`  in  N_REQ*WIDTH  per-requester data; requester k uses bits [k*WIDTH +: WIDTH].
- `ack_o`  out  N_REQ  one-hot, one-cycle pulse: requester k's word has been written.
- `fifo_wr_o`  out  1  connects to the FIFO `wr_i`.
- `fifo_din_o`  out  WIDTH  connects to the FIFO `din_i`.
- `fifo_full_i`  in  1  connects to the FIFO `full_o`.
- `grant_o`  out  $clog2(N_REQ)  index of the current or most recent winner.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation

- The state machine has three states: IDLE, WR and GAP.
- **IDLE**
  - If `|req_i` and `!fifo_full_i`, choose the winner by round-robin.
  - Round-robin search starts at index `last+1` and wraps modulo `N_REQ`. The first asserted `req_i` bit found wins.
  - Register `grant_o` as the winner and `fifo_din_o` as that requester's `data_i` slice. Go to WR.
  - Otherwise stay in IDLE; all outputs hold their values except `ack_o`, which is 0.
- **WR** (exactly one cycle)
  - `fifo_wr_o` = 1 and `ack_o[grant_o]` = 1.
  - Set `last` to `grant_o`, load the gap counter with `SETTLE-1`, and go to GAP.
- **GAP**
  - `fifo_wr_o` = 0 and `ack_o` = 0.
  - When the counter is 0, go to IDLE; otherwise decrement it.
- `fifo_din_o` is held stable from the WR cycle until the next IDLE-to-WR transition. This covers the FIFO's edge-detect delay.
- Requester contract:
  - Hold `req_i[k]` and `data_i[k]` stable until `ack_o[k]` is seen.
  - Deassert `req_i[k]` in the cycle after the ack unless another word is pending. If `req_i[k]` is still high on return to IDLE, it is treated as a new word.
  - A requester may withdraw `req_i` while the arbiter is in IDLE; no ack is issued.
  - `req_i` and `data_i` are ignored in WR and GAP.
- Full handling: `fifo_full_i` is sampled only in IDLE. If it is high, no grant is made and the round-robin pointer does not advance.
- Fairness: a requester that holds `req_i` is acked within `N_REQ` grants, provided the FIFO is not full.
- Reset values:
  - State IDLE.
  - `fifo_wr_o` = 0, `fifo_din_o` = 0, `ack_o` = 0, `grant_o` = 0, `busy_o` = 0.
  - `last` = `N_REQ-1`, so index 0 has first priority.
- Reset mid-operation, including during WR or GAP: at the next edge everything returns to its reset value. A request in flight is not acked and must be re-presented. The FIFO shares `rstn_i`, so no partial write survives.

## Timing

- Request at cycle t in IDLE with the FIFO not full:
  - Cycle t+1: WR, with `fifo_wr_o` = 1 and `ack_o` pulsing.
  - Cycles t+2 to t+1+SETTLE: GAP.
  - Cycle t+2+SETTLE: IDLE, and the next decision can be made.
- Maximum throughput is one word per `SETTLE+2` cycles; the default gives 1 per 4.
- Every `fifo_wr_o` high pulse lasts exactly 1 cycle and is followed by at least `SETTLE` low cycles. The FIFO's rising-edge detector therefore sees exactly one edge per grant.
- `ack_o` is coincident with `fifo_wr_o` and is never asserted in any other cycle.
- `busy_o` is high in the WR and GAP cycles.

## Test plan

- **Single requester:** `req_i`=4'b0100, `data_i[2]`=16'hA5A5, FIFO empty -> one cycle later `fifo_wr_o`=1, `ack_o`=4'b0100, `grant_o`=2, `fifo_din_o`=16'hA5A5. Then 2 low cycles, then the FIFO read returns 16'hA5A5.
- **All four requesting from reset:** `req_i`=4'b1111 with data 16'h0000, 16'h1111, 16'h2222, 16'h3333; each requester drops its request after its ack -> acks on requesters 0,1,2,3 in that order, 4 cycles apart. The FIFO then holds 0000, 1111, 2222, 3333 in order and `full_o`=1.
- **Full blocking:** FIFO full, `req_i`=4'b0001 held for 10 cycles -> no `fifo_wr_o` pulse and no ack. After one FIFO read, the FIFO empties a slot and the write and ack occur within 3 cycles.
- **Round-robin resume:** after requester 1 is acked, `req_i`=4'b0011 -> the next grant goes to requester 0, not requester 1. After requester 2 is acked, `req_i`=4'b0101 -> the next grant goes to requester 0 (the search wraps from index 3 to 0).
- **Reset mid-operation:** assert `rstn_i`=0 during the WR cycle -> at the next edge `fifo_wr_o`=0, `busy_o`=0 and `grant_o`=0, with no further ack. After release, `req_i`=4'b1000 is acked normally.
- **Withdrawal:** `req_i[3]` pulses high for 1 cycle only during a GAP -> no grant and no ack to requester 3.
